pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard controller for the in-order microprocessor pipeline.
- Sits beside the decode stage and tracks in-flight register writes in an internal scoreboard shift register.
- Generates decode stall, fetch/decode flush on taken branches, and operand-forwarding selects.
- Replaces the fixed single-stage, 3-bit-address, stall-only hazard logic; adds configurable depth, multi-cycle branch flush, load-use detection and saturating event counters.

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Decode-side hazard controller: scoreboard of in-flight register writes, stall, branch flush, event counters.
// Define PIPE_FWD_EN to enable operand forwarding with load-use detection.
module pipe_hazard_ctrl #(
    parameter int RAW       = 3,
    parameter int DEPTH     = 2,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RAW-1:0]   id_aa,
    input  logic [RAW-1:0]   id_ba,
    input  logic             id_ma,
    input  logic             id_mb,
    input  logic             id_rw,
    input  logic [RAW-1:0]   id_da,
    input  logic             id_load,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush,
    output logic [2:0]       fwd_a_sel,
    output logic [2:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                fcnt_q, fcnt_d;
    logic [DEPTH-1:0]          sb_valid_q, sb_valid_d;
    logic [DEPTH-1:0]          sb_load_q, sb_load_d;
    logic [DEPTH-1:0][RAW-1:0] sb_da_q, sb_da_d;
    logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
    logic [DEPTH-1:0]          match_a, match_b;
    logic                      stall_raw;
    logic                      push;

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_a[k] = id_valid && !id_ma && (id_aa != '0) && sb_valid_q[k] && (sb_da_q[k] == id_aa);
            match_b[k] = id_valid && !id_mb && (id_ba != '0) && sb_valid_q[k] && (sb_da_q[k] == id_ba);
        end
    end

`ifdef PIPE_FWD_EN
    logic use_a, use_b;

    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        // Scan oldest to youngest so the youngest match has the final word.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_a[k]) begin
                fwd_a_sel = 3'(k + 1);
                use_a     = sb_load_q[k] && (k == 0);
            end
            if (match_b[k]) begin
                fwd_b_sel = 3'(k + 1);
                use_b     = sb_load_q[k] && (k == 0);
            end
        end
        stall_raw = use_a || use_b;
    end
`else
    // Without forwarding the load tag carries no information.
    logic unused_sb_load;

    assign unused_sb_load = ^sb_load_q;
    assign fwd_a_sel      = '0;
    assign fwd_b_sel      = '0;
    assign stall_raw      = (|match_a) || (|match_b);
`endif

    assign flush = br_taken || (state_q == ST_FLUSH);
    assign stall = stall_raw && !flush;
    assign push  = id_valid && !stall && !flush && id_rw && (id_da != '0);

    always_comb begin
        sb_valid_d = '0;
        sb_load_d  = '0;
        sb_da_d    = '0;
        for (int k = 1; k < DEPTH; k++) begin
            sb_valid_d[k] = sb_valid_q[k-1];
            sb_load_d[k]  = sb_load_q[k-1];
            sb_da_d[k]    = sb_da_q[k-1];
        end
        sb_valid_d[0] = push;
        sb_load_d[0]  = id_load;
        sb_da_d[0]    = id_da;
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (br_taken) begin
            fcnt_d  = 4'(FLUSH_CYC - 1);
            state_d = (FLUSH_CYC > 1) ? ST_FLUSH : ST_RUN;
        end else if (state_q == ST_FLUSH) begin
            fcnt_d = fcnt_q - 4'd1;
            if (fcnt_q == 4'd1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            fcnt_q      <= '0;
            sb_valid_q  <= '0;
            sb_load_q   <= '0;
            sb_da_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            sb_valid_q  <= sb_valid_d;
            sb_load_q   <= sb_load_d;
            sb_da_q     <= sb_da_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against an age-based write-history model.
// Expectations follow PIPE_FWD_EN exactly as the design is compiled.
module tb_pipe_hazard_ctrl;
    localparam int RAW       = 3;
    localparam int DEPTH     = 2;
    localparam int FLUSH_CYC = 3;
    localparam int CNT_W     = 4;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam int HMAX      = 8192;

    typedef struct {
        bit v;
        int aa;
        int ba;
        bit ma;
        bit mb;
        bit rw;
        int da;
        bit ld;
        bit br;
    } row_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             id_valid, id_ma, id_mb, id_rw, id_load, br_taken;
    logic [RAW-1:0]   id_aa, id_ba, id_da;
    logic             stall, flush;
    logic [2:0]       fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipe_hazard_ctrl #(.RAW(RAW), .DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_aa(id_aa), .id_ba(id_ba),
        .id_ma(id_ma), .id_mb(id_mb), .id_rw(id_rw), .id_da(id_da), .id_load(id_load),
        .br_taken(br_taken), .stall(stall), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clock = ~clock;

    // Model: every accepted write is remembered by the cycle it issued in; its age gives the entry.
    int             cyc = 0;
    int             valid_from = 0;
    int             flush_until = -1;
    int             stall_n = 0;
    int             flush_n = 0;
    bit             wr_v  [HMAX];
    logic [RAW-1:0] wr_da [HMAX];
    bit             wr_ld [HMAX];
    bit             e_stall, e_flush, e_push;
    logic [2:0]     e_fa, e_fb;

    function automatic int youngest(input logic [RAW-1:0] src, input logic bypass);
        if (!id_valid || bypass || src == '0) return -1;
        for (int k = 0; k < DEPTH; k++) begin
            int c = cyc - 1 - k;
            if (c >= valid_from && wr_v[c % HMAX] && wr_da[c % HMAX] == src) return k;
        end
        return -1;
    endfunction

    function automatic bit newest_is_load();
        return wr_ld[(cyc - 1) % HMAX];
    endfunction

    task automatic model_eval();
        int ka, kb;
        bit raw;
        ka = youngest(id_aa, id_ma);
        kb = youngest(id_ba, id_mb);
`ifdef PIPE_FWD_EN
        raw  = (ka == 0 && newest_is_load()) || (kb == 0 && newest_is_load());
        e_fa = (ka < 0) ? 3'd0 : 3'(ka + 1);
        e_fb = (kb < 0) ? 3'd0 : 3'(kb + 1);
`else
        raw  = (ka >= 0) || (kb >= 0);
        e_fa = 3'd0;
        e_fb = 3'd0;
`endif
        e_flush = br_taken || (cyc <= flush_until);
        e_stall = raw && !e_flush;
        e_push  = id_valid && id_rw && (id_da != '0) && !e_stall && !e_flush;
    endtask

    task automatic model_reset();
        valid_from  = cyc;
        flush_until = -1;
        stall_n     = 0;
        flush_n     = 0;
    endtask

    task automatic drive(input row_t r);
        id_valid = r.v;
        id_aa    = RAW'(r.aa);
        id_ba    = RAW'(r.ba);
        id_ma    = r.ma;
        id_mb    = r.mb;
        id_rw    = r.rw;
        id_da    = RAW'(r.da);
        id_load  = r.ld;
        br_taken = r.br;
    endtask

    task automatic settle();
        @(negedge clock);
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clock);
        if (reset === 1'b0) begin
            cyc++;
            valid_from = cyc;
        end else begin
            wr_v[cyc % HMAX]  = e_push;
            wr_da[cyc % HMAX] = id_da;
            wr_ld[cyc % HMAX] = id_load;
            if (e_stall && stall_n < CMAX) stall_n++;
            if (e_flush && flush_n < CMAX) flush_n++;
            if (br_taken) flush_until = cyc + FLUSH_CYC - 1;
            cyc++;
        end
        #1;
    endtask

    task automatic hard_reset();
        row_t r;
        r = '{default: 0};
        drive(r);
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        row_t r;
        r = '{default: 0};
        drive(r);
        reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !== '0)
            $display("FAIL reset_power_on: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want all 0",
                     stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt);
        else n_pass++;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r = '{default: 0};
            r.v = 1;
            if (i == 0) begin r.rw = 1; r.da = 3; end
            else r.aa = 3;
            r.br = (i == 2);
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL reset_prep row %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            tick();
        end
        // Mid-flush, hazard input still present: reset must clear everything at once.
        r = '{default: 0};
        r.v = 1; r.aa = 3;
        drive(r);
        reset = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({stall, flush, stall_cnt, flush_cnt} !== '0)
            $display("FAIL reset_mid_run: got stall=%b flush=%b sc=%0d fc=%0d, want all 0",
                     stall, flush, stall_cnt, flush_cnt);
        else n_pass++;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = '{default: 0};
            r.v = 1;
            if (i == 0) begin r.rw = 1; r.da = 6; end
            else r.aa = 6;
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL reset_release row %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            if (i == 1) begin
                n_total++;
`ifdef PIPE_FWD_EN
                if (stall !== 1'b0 || fwd_a_sel !== 3'd1)
                    $display("FAIL reset_first_push: got stall=%b fa=%0d, want stall=0 fa=1", stall, fwd_a_sel);
`else
                if (stall !== 1'b1)
                    $display("FAIL reset_first_push: got stall=%b, want stall=1", stall);
`endif
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_raw_fwd();
        row_t r;
        hard_reset();
        for (int i = 0; i < 4; i++) begin
            r = '{default: 0};
            r.v = 1;
            if (i == 0) begin r.rw = 1; r.da = 5; end
            else begin r.aa = 5; r.ba = 5; end
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL raw_fwd row %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            if (i >= 1) begin
                n_total++;
`ifdef PIPE_FWD_EN
                if (i < 3 && (stall !== 1'b0 || fwd_b_sel !== 3'(i)))
                    $display("FAIL raw_fwd_sel row %0d: got stall=%b fb=%0d, want stall=0 fb=%0d", i, stall, fwd_b_sel, i);
                else if (i == 3 && fwd_b_sel !== 3'd0)
                    $display("FAIL raw_fwd_sel row 3: got fb=%0d, want 0", fwd_b_sel);
`else
                if (stall !== (i < 3) || (i == 3 && stall_cnt !== 4'd2))
                    $display("FAIL raw_stall row %0d: got stall=%b sc=%0d, want stall=%b sc=2 at end", i, stall, stall_cnt, (i < 3));
`endif
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        row_t r;
        hard_reset();
        for (int i = 0; i < 4; i++) begin
            r = '{default: 0};
            r.v = 1;
            if (i == 0) begin r.rw = 1; r.ld = 1; r.da = 2; end
            else r.aa = 2;
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL load_use row %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
`ifdef PIPE_FWD_EN
            if (i == 1 || i == 2) begin
                n_total++;
                if (stall !== (i == 1) || (i == 2 && fwd_a_sel !== 3'd2))
                    $display("FAIL load_use_fwd row %0d: got stall=%b fa=%0d, want stall=%b fa=2 on row 2", i, stall, fwd_a_sel, (i == 1));
                else n_pass++;
            end
`endif
            tick();
        end
    endtask

    task automatic test_branch_flush();
        row_t r;
        hard_reset();
        for (int i = 0; i < 5; i++) begin
            r = '{default: 0};
            r.v = 1;
            case (i)
                0:       begin r.rw = 1; r.da = 4; end
                1:       begin r.aa = 4; r.br = 1; end
                2:       begin r.aa = 4; r.rw = 1; r.da = 5; end
                3:       begin r.rw = 1; r.da = 5; end
                default: r.aa = 5;
            endcase
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL branch row %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            if (i >= 1) begin
                n_total++;
                if (flush !== (i < 4) || stall !== 1'b0 ||
                    (i == 4 && (flush_cnt !== 4'd3 || fwd_a_sel !== 3'd0)))
                    $display("FAIL branch_seq row %0d: got flush=%b stall=%b fc=%0d fa=%0d, want flush=%b stall=0 (row 4: fc=3 fa=0)",
                             i, flush, stall, flush_cnt, fwd_a_sel, (i < 4));
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        row_t r;
        hard_reset();
        for (int i = 0; i < 4; i++) begin
            r = '{default: 0};
            r.v = 1;
            case (i)
                0:       begin r.rw = 1; r.da = 0; end
                1:       begin r.aa = 0; r.ba = 0; end
                2:       begin r.rw = 1; r.da = 3; end
                default: begin r.aa = 3; r.ma = 1; r.ba = 3; r.mb = 1; end
            endcase
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL bypass row %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            if (i == 1 || i == 3) begin
                n_total++;
                if (stall !== 1'b0 || fwd_a_sel !== 3'd0 || fwd_b_sel !== 3'd0)
                    $display("FAIL bypass_nohaz row %0d: got stall=%b fa=%0d fb=%0d, want 0 0 0", i, stall, fwd_a_sel, fwd_b_sel);
                else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        row_t r;
        hard_reset();
        for (int i = 0; i < 60; i++) begin
            r = '{default: 0};
            r.v = 1;
            if (i % 3 == 0) begin r.rw = 1; r.ld = 1; r.da = 1; end
            else r.aa = 1;
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL saturation step %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         i, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            tick();
        end
        r = '{default: 0};
        drive(r);
        settle();
        n_total++;
        if (stall_cnt !== 4'hF)
            $display("FAIL saturation_hold: got sc=%0d, want 15", stall_cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        row_t r;
        hard_reset();
        for (int i = 0; i < 1500; i++) begin
            r.v  = ($urandom_range(0, 4) != 0);
            r.aa = int'($urandom_range(0, 3));
            r.ba = int'($urandom_range(0, 3));
            r.ma = ($urandom_range(0, 7) == 0);
            r.mb = ($urandom_range(0, 5) == 0);
            r.rw = ($urandom_range(0, 1) == 1);
            r.da = int'($urandom_range(0, 3));
            r.ld = ($urandom_range(0, 2) == 0);
            r.br = ($urandom_range(0, 11) == 0);
            drive(r);
            settle();
            n_total++;
            if ({stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt} !==
                {e_stall, e_flush, e_fa, e_fb, CNT_W'(stall_n), CNT_W'(flush_n)})
                $display("FAIL random cyc %0d: got stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d, want stall=%b flush=%b fa=%0d fb=%0d sc=%0d fc=%0d",
                         cyc, stall, flush, fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt,
                         e_stall, e_flush, e_fa, e_fb, stall_n, flush_n);
            else n_pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw_fwd();
        test_load_use();
        test_branch_flush();
        test_bypass();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
